// File: rtl/ct_lsu_sram_arb_ctrl_if.sv
// ---------------------------------------------------------------------------
// ct_lsu_sram_arb_ctrl_if
// Bundles the requester handshake and the SRAM macro pins of the LSU SRAM
// arbiter into one interface.
//   init_start/init_done          : array re-clear request / cleared status
//   wr_req/wr_addr/wr_data/wr_wen : write request (wen active-low per bit)
//   wr_gnt                        : write accepted this cycle
//   rd_req/rd_addr                : read request
//   rd_gnt/rd_vld/rd_data         : read accepted / read data valid / data
//   sram_a/sram_cen/sram_gwen     : SRAM address, chip enable, global wen
//   sram_d/sram_wen/sram_q        : SRAM write data, bit wen, read data
// Modport slave is the arbiter; modport master is the requester/SRAM side.
// ---------------------------------------------------------------------------
interface ct_lsu_sram_arb_ctrl_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 54
);
   logic                  init_start;
   logic                  init_done;
   logic                  wr_req;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] wr_wen;
   logic                  wr_gnt;
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_gnt;
   logic                  rd_vld;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_WIDTH-1:0] sram_a;
   logic                  sram_cen;
   logic                  sram_gwen;
   logic [DATA_WIDTH-1:0] sram_d;
   logic [DATA_WIDTH-1:0] sram_wen;
   logic [DATA_WIDTH-1:0] sram_q;

   modport slave (
      input  init_start, wr_req, wr_addr, wr_data, wr_wen,
             rd_req, rd_addr, sram_q,
      output init_done, wr_gnt, rd_gnt, rd_vld, rd_data,
             sram_a, sram_cen, sram_gwen, sram_d, sram_wen
   );

   modport master (
      output init_start, wr_req, wr_addr, wr_data, wr_wen,
             rd_req, rd_addr, sram_q,
      input  init_done, wr_gnt, rd_gnt, rd_vld, rd_data,
             sram_a, sram_cen, sram_gwen, sram_d, sram_wen
   );
endinterface

// File: rtl/ct_lsu_sram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// ct_lsu_sram_arb_ctrl
// Single-port SRAM arbiter for the LSU. After reset (or on init_start) it
// sweeps every address writing zeros, one per cycle. Afterwards it grants
// one write or read per cycle, combinationally, using round-robin on
// write/read conflicts. Read data returns one cycle after the grant and is
// held until the next read returns.
// Ports:
//   CLK  : clock
//   RST  : synchronous active-high reset
//   bus  : ct_lsu_sram_arb_ctrl_if.slave (requesters + SRAM pins)
// ---------------------------------------------------------------------------
module ct_lsu_sram_arb_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 54
) (
   input  logic                    CLK,
   input  logic                    RST,
   ct_lsu_sram_arb_ctrl_if.slave   bus
);

   typedef enum logic {
      ST_INIT,
      ST_IDLE
   } state_t;

   typedef enum logic {
      WIN_WR,
      WIN_RD
   } win_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic [ADDR_WIDTH-1:0] init_cnt_nxt;
   win_t                  last_win;
   win_t                  last_win_nxt;
   logic                  init_done_q;
   logic                  rd_vld_q;
   logic [DATA_WIDTH-1:0] rd_hold;

   logic                  wr_gnt_c;
   logic                  rd_gnt_c;
   logic [ADDR_WIDTH-1:0] sram_a_c;
   logic                  sram_cen_c;
   logic                  sram_gwen_c;
   logic [DATA_WIDTH-1:0] sram_d_c;
   logic [DATA_WIDTH-1:0] sram_wen_c;

   // Next-state, arbitration and SRAM pin drive. Everything is forced idle
   // while RST is high so the reset cycle never touches the array.
   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      last_win_nxt = last_win;
      wr_gnt_c     = 1'b0;
      rd_gnt_c     = 1'b0;
      sram_a_c     = '0;
      sram_cen_c   = 1'b1;
      sram_gwen_c  = 1'b1;
      sram_d_c     = '0;
      sram_wen_c   = '1;

      if (!RST) begin
         case (state)
            ST_INIT: begin
               sram_cen_c  = 1'b0;
               sram_gwen_c = 1'b0;
               sram_wen_c  = '0;
               sram_a_c    = init_cnt;
               // Counter stops at the last address instead of wrapping.
               if (init_cnt == '1) begin
                  state_nxt = ST_IDLE;
               end else begin
                  init_cnt_nxt = init_cnt + 1'b1;
               end
            end

            ST_IDLE: begin
               if (bus.init_start) begin
                  state_nxt    = ST_INIT;
                  init_cnt_nxt = '0;
               end else if (bus.wr_req && bus.rd_req) begin
                  // Conflict: the side that lost last conflict wins now.
                  if (last_win == WIN_WR) begin
                     rd_gnt_c     = 1'b1;
                     last_win_nxt = WIN_RD;
                  end else begin
                     wr_gnt_c     = 1'b1;
                     last_win_nxt = WIN_WR;
                  end
               end else if (bus.wr_req) begin
                  wr_gnt_c = 1'b1;
               end else if (bus.rd_req) begin
                  rd_gnt_c = 1'b1;
               end

               if (wr_gnt_c) begin
                  sram_cen_c  = 1'b0;
                  sram_gwen_c = 1'b0;
                  sram_a_c    = bus.wr_addr;
                  sram_d_c    = bus.wr_data;
                  sram_wen_c  = bus.wr_wen;
               end else if (rd_gnt_c) begin
                  sram_cen_c  = 1'b0;
                  sram_a_c    = bus.rd_addr;
               end
            end

            default: begin
               state_nxt = ST_INIT;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= ST_INIT;
         init_cnt    <= '0;
         last_win    <= WIN_WR;
         init_done_q <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_hold     <= '0;
      end else begin
         state       <= state_nxt;
         init_cnt    <= init_cnt_nxt;
         last_win    <= last_win_nxt;
         init_done_q <= (state_nxt == ST_IDLE);
         rd_vld_q    <= rd_gnt_c;
         if (rd_vld_q) begin
            rd_hold <= bus.sram_q;
         end
      end
   end

   assign bus.init_done = init_done_q;
   assign bus.wr_gnt    = wr_gnt_c;
   assign bus.rd_gnt    = rd_gnt_c;
   assign bus.rd_vld    = rd_vld_q;
   // SRAM output is live only in the return cycle; bypass it so data is
   // visible alongside rd_vld, then serve the held copy.
   assign bus.rd_data   = rd_vld_q ? bus.sram_q : rd_hold;
   assign bus.sram_a    = sram_a_c;
   assign bus.sram_cen  = sram_cen_c;
   assign bus.sram_gwen = sram_gwen_c;
   assign bus.sram_d    = sram_d_c;
   assign bus.sram_wen  = sram_wen_c;

endmodule

// File: tb/tb_ct_lsu_sram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_lsu_sram_arb_ctrl
// Directed bench for the LSU SRAM arbiter with a behavioural SRAM, a
// reference memory and a read-return scoreboard.
// ---------------------------------------------------------------------------
module tb_ct_lsu_sram_arb_ctrl;
   localparam int AW = 8;
   localparam int DW = 54;
   localparam logic [DW-1:0] WEN_LO8 = ~(DW'(8'hFF));
   localparam logic [DW-1:0] D_3A    = 54'h2A5A5A5A5A5A5;
   localparam logic [DW-1:0] D_A     = 54'h1234_5678_9ABC;
   localparam logic [DW-1:0] D_B     = 54'h3F_0F0F_0000_0001;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ct_lsu_sram_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ct_lsu_sram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // Behavioural single-port SRAM: read data one cycle after access.
   logic [DW-1:0] sram_mem [0:255];
   logic [DW-1:0] q_r;
   always @(posedge clk) begin
      if (!bus.sram_cen) begin
         if (!bus.sram_gwen)
            sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) |
                                    (bus.sram_d & ~bus.sram_wen);
         else
            q_r <= sram_mem[bus.sram_a];
      end
   end
   assign bus.sram_q = q_r;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            c;
      logic [DW-1:0] d;
   } rd_exp_t;

   rd_exp_t       sb [$];
   logic [DW-1:0] ref_mem [0:255];
   logic          exp_last_rd;   // 0: write won the last conflict
   int            total = 0;
   int            bad   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [DW-1:0] ww, input logic rd, input logic [AW-1:0] ra,
                        input logic ist);
      bus.wr_req     = wr;
      bus.wr_addr    = wa;
      bus.wr_data    = wd;
      bus.wr_wen     = ww;
      bus.rd_req     = rd;
      bus.rd_addr    = ra;
      bus.init_start = ist;
   endtask

   // One IDLE-state cycle: drive, check grants/SRAM pins against the
   // round-robin model, check any read return, update the models.
   task automatic step(input string tag, input logic wr, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [DW-1:0] ww, input logic rd,
                       input logic [AW-1:0] ra, input logic ist);
      logic          ewg, erg, exp_vld;
      logic [DW-1:0] obs_d;
      logic [127:0]  exp_v;
      ewg = 1'b0;
      erg = 1'b0;
      if (!ist) begin
         if (wr && rd) begin
            erg = !exp_last_rd;
            ewg = exp_last_rd;
            exp_last_rd = erg;
         end else begin
            ewg = wr;
            erg = rd;
         end
      end
      drive(wr, wa, wd, ww, rd, ra, ist);
      #4;
      if (ewg)      exp_v = 128'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, wa, wd, ww});
      else if (erg) exp_v = 128'({1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ra, DW'(0), {DW{1'b1}}});
      else          exp_v = 128'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, AW'(0), DW'(0), {DW{1'b1}}});
      obs_d = erg ? '0 : bus.sram_d;
      chk({tag, "/bus"}, 128'({bus.init_done, bus.wr_gnt, bus.rd_gnt, bus.sram_cen,
                               bus.sram_gwen, bus.sram_a, obs_d, bus.sram_wen}), exp_v);
      exp_vld = (sb.size() > 0) && (sb[0].c == cyc);
      chk({tag, "/rd_vld"}, 128'(bus.rd_vld), 128'(exp_vld));
      if (exp_vld) begin
         chk({tag, "/rd_data"}, 128'(bus.rd_data), 128'(sb[0].d));
         void'(sb.pop_front());
      end
      if (erg) sb.push_back('{cyc + 1, ref_mem[ra]});
      if (ewg) ref_mem[wa] = (ref_mem[wa] & ww) | (wd & ~ww);
      @(posedge clk);
      #1;
   endtask

   // INIT sweep of n cycles with both requests held high; init_start is
   // pulsed at cycle pulse_at (ignored by the DUT).
   task automatic sweep(input string tag, input int n, input int pulse_at);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, AW'(i + 7), DW'(i), '0, 1'b1, AW'(i + 3), (i == pulse_at));
         #4;
         chk($sformatf("%s/c%0d", tag, i),
             128'({bus.init_done, bus.rd_vld, bus.wr_gnt, bus.rd_gnt, bus.sram_cen,
                   bus.sram_gwen, bus.sram_a, bus.sram_d, bus.sram_wen}),
             128'({4'b0000, 1'b0, 1'b0, AW'(i), DW'(0), DW'(0)}));
         @(posedge clk);
         #1;
      end
      if (n == 256)
         for (int a = 0; a < 256; a++) ref_mem[a] = '0;
   endtask

   task automatic rst_cycle(input string tag);
      rst = 1'b1;
      drive(1'b1, 8'h11, '1, '0, 1'b1, 8'h22, 1'b1);
      #4;
      chk({tag, "/rst_pins"}, 128'({bus.wr_gnt, bus.rd_gnt, bus.sram_cen}), 128'(3'b001));
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_last_rd = 1'b0;
      sb.delete();
      #1;
      chk({tag, "/rst_state"}, 128'({bus.init_done, bus.rd_vld, bus.rd_data}), 128'(0));
   endtask

   initial begin
      rst = 1'b1;
      exp_last_rd = 1'b0;
      drive(1'b1, '0, '0, '1, 1'b1, '0, 1'b0);
      @(posedge clk);
      #1;

      // Power-up reset, then full sweep with requests held high.
      rst_cycle("por");
      sweep("sweep0", 256, -1);

      // Continuous conflict from the first IDLE cycle: rd, wr, rd, wr.
      // The second read sees the write of the preceding cycle.
      step("conf0", 1'b1, 8'h10, D_A, '0, 1'b1, 8'h10, 1'b0);
      step("conf1", 1'b1, 8'h10, D_A, '0, 1'b1, 8'h10, 1'b0);
      step("conf2", 1'b1, 8'h10, D_A, '0, 1'b1, 8'h10, 1'b0);
      step("conf3", 1'b1, 8'h10, D_A, '0, 1'b1, 8'h10, 1'b0);
      step("idle0", 1'b0, '0, '0, '1, 1'b0, '0, 1'b0);

      // Full write then read back.
      step("wr3a", 1'b1, 8'h3A, D_3A, '0, 1'b0, '0, 1'b0);
      step("rd3a", 1'b0, '0, '0, '1, 1'b1, 8'h3A, 1'b0);
      step("idle1", 1'b0, '0, '0, '1, 1'b0, '0, 1'b0);

      // Partial write: only the low 8 bits enabled.
      step("wr5", 1'b1, 8'h05, '1, WEN_LO8, 1'b0, '0, 1'b0);
      step("rd5", 1'b0, '0, '0, '1, 1'b1, 8'h05, 1'b0);
      step("idle2", 1'b0, '0, '0, '1, 1'b0, '0, 1'b0);

      // Round-robin state only moves on conflicts.
      step("conf4", 1'b1, 8'h20, D_B, '0, 1'b1, 8'h3A, 1'b0);
      step("rdonly", 1'b0, '0, '0, '1, 1'b1, 8'h05, 1'b0);
      step("conf5", 1'b1, 8'h20, D_B, '0, 1'b1, 8'h05, 1'b0);
      step("rd20", 1'b0, '0, '0, '1, 1'b1, 8'h20, 1'b0);
      step("idle3", 1'b0, '0, '0, '1, 1'b0, '0, 1'b0);

      // init_start in IDLE grants nothing; a second pulse mid-sweep is ignored.
      step("istart1", 1'b1, 8'h3A, D_B, '0, 1'b1, 8'h3A, 1'b1);
      sweep("sweep1", 256, 10);
      step("rd3a_clr", 1'b0, '0, '0, '1, 1'b1, 8'h3A, 1'b0);
      step("idle4", 1'b0, '0, '0, '1, 1'b0, '0, 1'b0);

      // Reset at counter 100 restarts the sweep from address 0.
      step("wr7", 1'b1, 8'h07, D_A, '0, 1'b0, '0, 1'b0);
      step("istart2", 1'b0, '0, '0, '1, 1'b0, '0, 1'b1);
      sweep("sweep2a", 100, -1);
      rst_cycle("rst_mid");
      sweep("sweep2b", 256, -1);
      step("rd7_clr", 1'b0, '0, '0, '1, 1'b1, 8'h07, 1'b0);
      step("idle5", 1'b0, '0, '0, '1, 1'b0, '0, 1'b0);
      chk("sb_empty", 128'(sb.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global timeout so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
